dmem_arbiter: RTL and testbench

- Owns the single-port data BRAM and shares it between the pipeline MEM stage (CPU port) and the UART program loader (loader port).
- Generates store byte-enables and lane-replicated write data, and tracks 1-cycle read latency.
- Hosts the free-running hardware cycle counter and answers CPU reads of `HARDWARE_COUNTER_ADDR`.
- Returns raw 32-bit words; byte/half extraction stays in the downstream load-filter stage.

---
 rtl/dmem_arbiter_if.sv | 67 ++++++
 rtl/dmem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles every bus-level signal of the data-memory arbiter:
//   CPU port    : c_req, c_we, c_addr, c_wdata, c_funct3 -> c_gnt, c_stall,
//                 c_rvalid, c_rdata
//   Loader port : l_req, l_we, l_addr, l_wdata -> l_gnt, l_rvalid, l_rdata
//   BRAM port   : m_en, m_we, m_addr, m_wdata <- m_rdata
//   Status      : counter (free-running cycle counter), misalign pulse
// Modports:
//   slave  - the arbiter side (drives grants, responses and BRAM controls)
//   master - the environment side (CPU, loader and BRAM model)
// Also provides the default HARDWARE_COUNTER_ADDR (overridable with a define).
// ---------------------------------------------------------------------------
`ifndef HARDWARE_COUNTER_ADDR
`define HARDWARE_COUNTER_ADDR 32'hFFFF_0000
`endif

interface dmem_arbiter_if #(
    parameter int ADDR_W = 12
);
    logic              c_req;
    logic              c_we;
    logic [31:0]       c_addr;
    logic [31:0]       c_wdata;
    logic [2:0]        c_funct3;
    logic              c_gnt;
    logic              c_stall;
    logic              c_rvalid;
    logic [31:0]       c_rdata;

    logic              l_req;
    logic              l_we;
    logic [31:0]       l_addr;
    logic [31:0]       l_wdata;
    logic              l_gnt;
    logic              l_rvalid;
    logic [31:0]       l_rdata;

    logic              m_en;
    logic [3:0]        m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata;

    logic [31:0]       counter;
    logic              misalign;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata, c_funct3,
        output c_gnt, c_stall, c_rvalid, c_rdata,
        input  l_req, l_we, l_addr, l_wdata,
        output l_gnt, l_rvalid, l_rdata,
        output m_en, m_we, m_addr, m_wdata,
        input  m_rdata,
        output counter, misalign
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata, c_funct3,
        input  c_gnt, c_stall, c_rvalid, c_rdata,
        output l_req, l_we, l_addr, l_wdata,
        input  l_gnt, l_rvalid, l_rdata,
        input  m_en, m_we, m_addr, m_wdata,
        output m_rdata,
        input  counter, misalign
    );
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port data BRAM between the MEM-stage CPU port and the
// UART program loader. Builds store byte-enables and lane-replicated write
// data, tracks the 1-cycle read latency, hosts the free-running cycle
// counter and answers CPU word reads of HARDWARE_COUNTER_ADDR with it.
// Read responses are raw 32-bit words.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   bus   - dmem_arbiter_if.slave (CPU, loader, BRAM, counter, misalign)
// Parameters:
//   ADDR_W      - BRAM word-address width (depth 2**ADDR_W words)
//   LOADER_PRIO - 1: loader wins every conflict, 0: alternate on conflict
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   - misaligned CPU half/word accesses are granted but not issued,
//               misalign pulses at T+1 and reads return 0
//   undefined - misalign tied 0, misaligned offsets silently truncated
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W      = 12,
    parameter int LOADER_PRIO = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     bus
);

    typedef enum logic { OWNER_CPU = 1'b0, OWNER_LOADER = 1'b1 } owner_e;
    typedef enum logic [1:0] { SRC_MEM, SRC_COUNTER, SRC_ZERO } src_e;

    localparam logic [31:0] CTR_ADDR = `HARDWARE_COUNTER_ADDR;

    owner_e      last_owner_q, last_owner_d;
    owner_e      rd_owner_q,   rd_owner_d;
    src_e        rd_src_q,     rd_src_d;
    logic        rd_pend_q,    rd_pend_d;
    logic        misalign_q,   misalign_d;
    logic [31:0] counter_q,    counter_d;
    logic [31:0] snap_q,       snap_d;
    logic [31:0] c_hold_q,     c_hold_d;
    logic [31:0] l_hold_q,     l_hold_d;

    logic              c_gnt, l_gnt, any_gnt, acc_we, in_range, is_ctr;
    logic              misal, issue, cpu_word, c_rvalid, l_rvalid;
    logic [31:0]       acc_addr, cpu_wdata, sel_wdata, resp_data;
    logic [31:0]       c_rdata, l_rdata;
    logic [3:0]        cpu_be, sel_be;
    logic [1:0]        off;

    // Arbitration, address decode, BRAM drive and next-state of every flop.
    always_comb begin
        c_gnt     = 1'b0;
        l_gnt     = 1'b0;
        cpu_be    = 4'b1111;
        cpu_wdata = bus.c_wdata;
        cpu_word  = 1'b0;
        misal     = 1'b0;

        if (bus.c_req && bus.l_req) begin
            // On conflict the requester that did not win last time goes next.
            if (LOADER_PRIO != 0)                 l_gnt = 1'b1;
            else if (last_owner_q == OWNER_CPU)   l_gnt = 1'b1;
            else                                  c_gnt = 1'b1;
        end else if (bus.c_req) begin
            c_gnt = 1'b1;
        end else if (bus.l_req) begin
            l_gnt = 1'b1;
        end
        any_gnt = c_gnt | l_gnt;

        acc_addr = c_gnt ? bus.c_addr : bus.l_addr;
        acc_we   = c_gnt ? bus.c_we   : bus.l_we;
        off      = bus.c_addr[1:0];
        is_ctr   = (acc_addr == CTR_ADDR);
        in_range = ((acc_addr >> (ADDR_W + 2)) == 32'd0) && !is_ctr;

        // funct3[2] only selects sign handling downstream, so it is a don't-care.
        casez (bus.c_funct3)
            3'b?00: begin
                cpu_be    = 4'b0001 << off;
                cpu_wdata = {4{bus.c_wdata[7:0]}};
            end
            3'b?01: begin
                cpu_be    = 4'b0011 << {off[1], 1'b0};
                cpu_wdata = {2{bus.c_wdata[15:0]}};
`ifdef DMEM_MISALIGN_TRAP_EN
                misal     = c_gnt && off[0];
`endif
            end
            default: begin
                cpu_word  = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
                misal     = c_gnt && (off != 2'b00);
`endif
            end
        endcase

        sel_be    = c_gnt ? cpu_be    : 4'b1111;
        sel_wdata = c_gnt ? cpu_wdata : bus.l_wdata;
        issue     = any_gnt && in_range && !misal;

        last_owner_d = last_owner_q;
        if (c_gnt)      last_owner_d = OWNER_CPU;
        else if (l_gnt) last_owner_d = OWNER_LOADER;

        rd_pend_d  = any_gnt && !acc_we;
        rd_owner_d = c_gnt ? OWNER_CPU : OWNER_LOADER;
        if (issue)
            rd_src_d = SRC_MEM;
        else if (c_gnt && is_ctr && cpu_word && !misal)
            rd_src_d = SRC_COUNTER;
        else
            rd_src_d = SRC_ZERO;

        snap_d     = counter_q;
        counter_d  = counter_q + 32'd1;
        misalign_d = misal;

        // Response in T+1; each port otherwise holds its last returned word.
        case (rd_src_q)
            SRC_MEM:     resp_data = bus.m_rdata;
            SRC_COUNTER: resp_data = snap_q;
            default:     resp_data = 32'd0;
        endcase
        c_rvalid = rd_pend_q && (rd_owner_q == OWNER_CPU);
        l_rvalid = rd_pend_q && (rd_owner_q == OWNER_LOADER);
        c_rdata  = c_rvalid ? resp_data : c_hold_q;
        l_rdata  = l_rvalid ? resp_data : l_hold_q;
        c_hold_d = c_rdata;
        l_hold_d = l_rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_q <= OWNER_LOADER;
            rd_owner_q   <= OWNER_CPU;
            rd_src_q     <= SRC_ZERO;
            rd_pend_q    <= 1'b0;
            misalign_q   <= 1'b0;
            counter_q    <= 32'd0;
            snap_q       <= 32'd0;
            c_hold_q     <= 32'd0;
            l_hold_q     <= 32'd0;
        end else begin
            last_owner_q <= last_owner_d;
            rd_owner_q   <= rd_owner_d;
            rd_src_q     <= rd_src_d;
            rd_pend_q    <= rd_pend_d;
            misalign_q   <= misalign_d;
            counter_q    <= counter_d;
            snap_q       <= snap_d;
            c_hold_q     <= c_hold_d;
            l_hold_q     <= l_hold_d;
        end
    end

    assign bus.c_gnt    = c_gnt;
    assign bus.c_stall  = bus.c_req && !c_gnt;
    assign bus.c_rvalid = c_rvalid;
    assign bus.c_rdata  = c_rdata;
    assign bus.l_gnt    = l_gnt;
    assign bus.l_rvalid = l_rvalid;
    assign bus.l_rdata  = l_rdata;
    assign bus.m_en     = issue;
    assign bus.m_we     = (issue && acc_we) ? sel_be : 4'b0000;
    assign bus.m_addr   = any_gnt ? acc_addr[ADDR_W+1:2] : '0;
    assign bus.m_wdata  = (issue && acc_we) ? sel_wdata : 32'd0;
    assign bus.counter  = counter_q;
    assign bus.misalign = misalign_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed testbench for dmem_arbiter (ADDR_W = 12, LOADER_PRIO = 0) with a
// simple registered BRAM model attached to the memory port. Inputs change on
// the falling clock edge; outputs are sampled on/just after the falling edge.
// ---------------------------------------------------------------------------
`ifndef HARDWARE_COUNTER_ADDR
`define HARDWARE_COUNTER_ADDR 32'hFFFF_0000
`endif

module tb_dmem_arbiter;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    logic [31:0] bram [0:4095];
    logic [31:0] bram_rdata;

    dmem_arbiter_if #(.ADDR_W(12)) bus ();

    dmem_arbiter #(.ADDR_W(12), .LOADER_PRIO(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port BRAM with byte enables and one cycle of read latency.
    always @(posedge clk) begin
        if (bus.m_en) begin
            for (int b = 0; b < 4; b++)
                if (bus.m_we[b]) bram[bus.m_addr][8*b +: 8] <= bus.m_wdata[8*b +: 8];
            bram_rdata <= bram[bus.m_addr];
        end
    end
    assign bus.m_rdata = bram_rdata;

    task automatic clear_reqs();
        bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = 32'd0;
        bus.c_wdata = 32'd0; bus.c_funct3 = 3'b010;
        bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_addr = 32'd0; bus.l_wdata = 32'd0;
    endtask

    task automatic cpu_drive(input logic we, input logic [31:0] addr,
                             input logic [31:0] data, input logic [2:0] f3);
        bus.c_req = 1'b1; bus.c_we = we; bus.c_addr = addr;
        bus.c_wdata = data; bus.c_funct3 = f3;
    endtask

    task automatic ldr_drive(input logic we, input logic [31:0] addr, input logic [31:0] data);
        bus.l_req = 1'b1; bus.l_we = we; bus.l_addr = addr; bus.l_wdata = data;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.counter !== 32'd0 || bus.m_en !== 1'b0 || bus.m_we !== 4'd0 ||
            bus.c_gnt !== 1'b0 || bus.c_rvalid !== 1'b0 || bus.l_rvalid !== 1'b0 ||
            bus.misalign !== 1'b0 || bus.c_rdata !== 32'd0 || bus.l_rdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got counter=%h m_en=%b m_we=%b c_gnt=%b c_rv=%b l_rv=%b mis=%b, expected all 0",
                     bus.counter, bus.m_en, bus.m_we, bus.c_gnt, bus.c_rvalid, bus.l_rvalid, bus.misalign);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.counter !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_counter_held: got %h expected 00000000", bus.counter);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_conflict();
        cpu_drive(1'b0, 32'h0, 32'h0, 3'b010);
        ldr_drive(1'b0, 32'h4, 32'h0);
        #1;
        checks++;
        if (bus.c_gnt !== 1'b1 || bus.l_gnt !== 1'b0 || bus.c_stall !== 1'b0) begin
            errors++;
            $display("[TB] FAIL conflict_first: got c_gnt=%b l_gnt=%b c_stall=%b expected 1 0 0",
                     bus.c_gnt, bus.l_gnt, bus.c_stall);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.c_gnt !== 1'b0 || bus.l_gnt !== 1'b1 || bus.c_stall !== 1'b1 || bus.c_rvalid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL conflict_second: got c_gnt=%b l_gnt=%b c_stall=%b c_rvalid=%b expected 0 1 1 1",
                     bus.c_gnt, bus.l_gnt, bus.c_stall, bus.c_rvalid);
        end
        @(negedge clk);
        clear_reqs();
        checks++;
        if (bus.l_rvalid !== 1'b1 || bus.c_rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL conflict_resp: got l_rvalid=%b c_rvalid=%b expected 1 0",
                     bus.l_rvalid, bus.c_rvalid);
        end
    endtask

    task automatic test_loader_write();
        logic [31:0] addrs [4] = '{32'h0, 32'h4, 32'h8, 32'h100};
        logic [31:0] datas [4] = '{32'h11, 32'h22, 32'h33, 32'h0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ldr_drive(1'b1, addrs[i], datas[i]);
            #1;
            checks++;
            if (bus.l_gnt !== 1'b1 || bus.m_en !== 1'b1 || bus.m_we !== 4'b1111 ||
                bus.m_addr !== addrs[i][13:2] || bus.m_wdata !== datas[i]) begin
                errors++;
                $display("[TB] FAIL loader_write[%0d]: got gnt=%b en=%b we=%b addr=%h wdata=%h expected 1 1 1111 %h %h",
                         i, bus.l_gnt, bus.m_en, bus.m_we, bus.m_addr, bus.m_wdata, addrs[i][13:2], datas[i]);
            end
        end
        @(negedge clk);
        clear_reqs();
        checks++;
        if (bus.l_rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL loader_write_no_rvalid: got %b expected 0", bus.l_rvalid);
        end
    endtask

    task automatic test_stores();
        @(negedge clk);
        cpu_drive(1'b1, 32'h0000_0102, 32'h0000_00AB, 3'b000);
        #1;
        checks++;
        if (bus.m_en !== 1'b1 || bus.m_we !== 4'b0100 || bus.m_addr !== 12'h040 ||
            bus.m_wdata !== 32'hABAB_ABAB || bus.c_gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL store_byte: got en=%b we=%b addr=%h wdata=%h gnt=%b expected 1 0100 040 ababab ab 1",
                     bus.m_en, bus.m_we, bus.m_addr, bus.m_wdata, bus.c_gnt);
        end
        @(negedge clk);
        checks++;
        if (bus.c_rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL store_no_rvalid: got %b expected 0", bus.c_rvalid);
        end
        cpu_drive(1'b1, 32'h0000_0106, 32'h1234_BEEF, 3'b001);
        #1;
        checks++;
        if (bus.m_we !== 4'b1100 || bus.m_addr !== 12'h041 || bus.m_wdata !== 32'hBEEF_BEEF) begin
            errors++;
            $display("[TB] FAIL store_half: got we=%b addr=%h wdata=%h expected 1100 041 beefbeef",
                     bus.m_we, bus.m_addr, bus.m_wdata);
        end
        @(negedge clk);
        cpu_drive(1'b1, 32'h0000_010C, 32'hDEAD_BEEF, 3'b010);
        #1;
        checks++;
        if (bus.m_we !== 4'b1111 || bus.m_addr !== 12'h043 || bus.m_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL store_word: got we=%b addr=%h wdata=%h expected 1111 043 deadbeef",
                     bus.m_we, bus.m_addr, bus.m_wdata);
        end
        @(negedge clk);
        clear_reqs();
        ldr_drive(1'b0, 32'h0000_0100, 32'h0);
        @(negedge clk);
        clear_reqs();
        checks++;
        if (bus.l_rvalid !== 1'b1 || bus.l_rdata !== 32'h00AB_0000) begin
            errors++;
            $display("[TB] FAIL store_byte_readback: got rvalid=%b rdata=%h expected 1 00ab0000",
                     bus.l_rvalid, bus.l_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] expv [3] = '{32'h11, 32'h22, 32'h33};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (bus.c_rvalid !== 1'b1 || bus.c_rdata !== expv[i-1]) begin
                    errors++;
                    $display("[TB] FAIL back_to_back[%0d]: got rvalid=%b rdata=%h expected 1 %h",
                             i - 1, bus.c_rvalid, bus.c_rdata, expv[i-1]);
                end
            end
            if (i < 3) cpu_drive(1'b0, 32'(4 * i), 32'h0, 3'b010);
            else       clear_reqs();
        end
        @(negedge clk);
        checks++;
        if (bus.c_rvalid !== 1'b0 || bus.c_rdata !== 32'h33) begin
            errors++;
            $display("[TB] FAIL rdata_hold: got rvalid=%b rdata=%h expected 0 00000033",
                     bus.c_rvalid, bus.c_rdata);
        end
    endtask

    task automatic test_counter_read();
        rst_n = 1'b0;
        clear_reqs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        cpu_drive(1'b0, `HARDWARE_COUNTER_ADDR, 32'h0, 3'b010);
        #1;
        checks++;
        if (bus.counter !== 32'h64 || bus.m_en !== 1'b0 || bus.c_gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL counter_req: got counter=%h m_en=%b gnt=%b expected 00000064 0 1",
                     bus.counter, bus.m_en, bus.c_gnt);
        end
        @(negedge clk);
        checks++;
        if (bus.c_rvalid !== 1'b1 || bus.c_rdata !== 32'h64 || bus.counter !== 32'h65) begin
            errors++;
            $display("[TB] FAIL counter_resp: got rvalid=%b rdata=%h counter=%h expected 1 00000064 00000065",
                     bus.c_rvalid, bus.c_rdata, bus.counter);
        end
        cpu_drive(1'b1, `HARDWARE_COUNTER_ADDR, 32'h1234_5678, 3'b010);
        #1;
        checks++;
        if (bus.m_en !== 1'b0 || bus.m_we !== 4'b0000 || bus.c_gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL counter_write_dropped: got en=%b we=%b gnt=%b expected 0 0000 1",
                     bus.m_en, bus.m_we, bus.c_gnt);
        end
        @(negedge clk);
        clear_reqs();
    endtask

    task automatic test_out_of_range();
        cpu_drive(1'b0, 32'h0001_0000, 32'h0, 3'b010);
        #1;
        checks++;
        if (bus.m_en !== 1'b0 || bus.c_gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL oor_read_req: got en=%b gnt=%b expected 0 1", bus.m_en, bus.c_gnt);
        end
        @(negedge clk);
        checks++;
        if (bus.c_rvalid !== 1'b1 || bus.c_rdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL oor_read_resp: got rvalid=%b rdata=%h expected 1 00000000",
                     bus.c_rvalid, bus.c_rdata);
        end
        cpu_drive(1'b1, 32'h0001_0000, 32'hFFFF_FFFF, 3'b010);
        #1;
        checks++;
        if (bus.m_en !== 1'b0 || bus.m_we !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL oor_write: got en=%b we=%b expected 0 0000", bus.m_en, bus.m_we);
        end
        @(negedge clk);
        clear_reqs();
    endtask

    task automatic test_misalign();
        cpu_drive(1'b0, 32'h0000_0006, 32'h0, 3'b010);
        #1;
`ifdef DMEM_MISALIGN_TRAP_EN
        checks++;
        if (bus.m_en !== 1'b0 || bus.c_gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL misalign_req: got en=%b gnt=%b expected 0 1", bus.m_en, bus.c_gnt);
        end
        @(negedge clk);
        clear_reqs();
        checks++;
        if (bus.misalign !== 1'b1 || bus.c_rvalid !== 1'b1 || bus.c_rdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL misalign_resp: got mis=%b rvalid=%b rdata=%h expected 1 1 00000000",
                     bus.misalign, bus.c_rvalid, bus.c_rdata);
        end
`else
        checks++;
        if (bus.m_en !== 1'b1 || bus.m_addr !== 12'h001) begin
            errors++;
            $display("[TB] FAIL misalign_req: got en=%b addr=%h expected 1 001", bus.m_en, bus.m_addr);
        end
        @(negedge clk);
        clear_reqs();
        checks++;
        if (bus.misalign !== 1'b0 || bus.c_rvalid !== 1'b1 || bus.c_rdata !== 32'h22) begin
            errors++;
            $display("[TB] FAIL misalign_resp: got mis=%b rvalid=%b rdata=%h expected 0 1 00000022",
                     bus.misalign, bus.c_rvalid, bus.c_rdata);
        end
`endif
        @(negedge clk);
        checks++;
        if (bus.misalign !== 1'b0) begin
            errors++;
            $display("[TB] FAIL misalign_pulse_width: got %b expected 0", bus.misalign);
        end
    endtask

    task automatic test_reset_mid_read();
        ldr_drive(1'b0, 32'h0000_0010, 32'h0);
        #1;
        checks++;
        if (bus.l_gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midread_gnt: got %b expected 1", bus.l_gnt);
        end
        @(negedge clk);
        rst_n = 1'b0;
        clear_reqs();
        #1;
        checks++;
        if (bus.l_rvalid !== 1'b0 || bus.counter !== 32'd0 || bus.m_en !== 1'b0 ||
            bus.l_rdata !== 32'd0 || bus.c_rdata !== 32'd0 || bus.c_rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midread_reset: got l_rv=%b counter=%h en=%b l_rdata=%h c_rdata=%h expected all 0",
                     bus.l_rvalid, bus.counter, bus.m_en, bus.l_rdata, bus.c_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.l_rvalid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midread_after_release[%0d]: got l_rvalid=%b expected 0", i, bus.l_rvalid);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        clear_reqs();
        test_reset();
        test_conflict();
        test_loader_write();
        test_stores();
        test_back_to_back();
        test_counter_read();
        test_out_of_range();
        test_misalign();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
